noc_flit_injector: RTL and testbench



---
 rtl/noc_flit_injector_if.sv | 36 +++
 rtl/noc_flit_injector.sv | 122 ++++++++++++
 tb/tb_noc_flit_injector.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_flit_injector_if.sv
// Request, payload and FIFO-write bundle for the NoC flit injector.
// The injector itself sits on the slave side.
interface noc_flit_injector_if #(
   parameter int flit_width = 32,
   parameter int addr_width = 4,
   parameter int len_width  = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic [addr_width-1:0]   req_dest;
   logic [addr_width-1:0]   req_src;
   logic [len_width-1:0]    req_len;
   logic                    pay_valid;
   logic                    pay_ready;
   logic [flit_width-3:0]   pay_data;
   logic [flit_width-1:0]   flit_out;
   logic                    enq;
   logic                    full;
   logic                    busy;
   logic                    drop_err;
   logic [15:0]             pkt_count;

   modport master (
      output req_valid, req_dest, req_src, req_len,
      output pay_valid, pay_data, full,
      input  req_ready, pay_ready, flit_out, enq,
      input  busy, drop_err, pkt_count
   );

   modport slave (
      input  req_valid, req_dest, req_src, req_len,
      input  pay_valid, pay_data, full,
      output req_ready, pay_ready, flit_out, enq,
      output busy, drop_err, pkt_count
   );
endinterface

// File: rtl/noc_flit_injector.sv
// Packet-to-flit injector: HEAD, BODY..., TAIL(xor checksum) into a
// NoC input FIFO through an enq/full write port.
module noc_flit_injector #(
   parameter int flit_width     = 32,
   parameter int addr_width     = 4,
   parameter int len_width      = 4,
   parameter bit allow_loopback = 1'b0
) (
   input logic          clock,
   input logic          reset,
   noc_flit_injector_if.slave bus
);
   localparam int pw = flit_width - 2;
   localparam int hw = 2 + 2 * addr_width + len_width;

   typedef enum logic [1:0] {
      IDLE,
      HEAD,
      BODY,
      TAIL
   } state_t;

   state_t                state;
   logic [addr_width-1:0] dest;
   logic [addr_width-1:0] src;
   logic [len_width-1:0]  len;
   logic [len_width-1:0]  cnt;
   logic [pw-1:0]         checksum;
   logic [15:0]           pkt_count;
   logic                  drop_err;
   logic [flit_width-1:0] head_flit;
   logic                  self_addr;

   assign self_addr     = (bus.req_dest == bus.req_src) && !allow_loopback;
   assign bus.busy      = (state != IDLE);
   assign bus.drop_err  = drop_err;
   assign bus.pkt_count = pkt_count;

   // Header: type, dest, src, len packed from the MSB, zero padded below
   always_comb begin
      head_flit = '0;
      head_flit[flit_width-1 -: hw] = {2'b01, dest, src, len};
   end

   // Flit mux and FIFO/payload handshakes, decoded from the current state
   always_comb begin
      bus.flit_out  = '0;
      bus.enq       = 1'b0;
      bus.pay_ready = 1'b0;
      bus.req_ready = 1'b0;
      unique case (state)
         IDLE: bus.req_ready = 1'b1;
         HEAD: begin
            bus.flit_out = head_flit;
            bus.enq      = !bus.full;
         end
         BODY: begin
            bus.flit_out  = {2'b00, bus.pay_data};
            bus.pay_ready = !bus.full;
            bus.enq       = bus.pay_valid && !bus.full;
         end
         TAIL: begin
            bus.flit_out = {2'b10, checksum};
            bus.enq      = !bus.full;
         end
         default: ;
      endcase
   end

   // Packet sequencer: latches the request, counts payload, folds checksum
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dest      <= '0;
         src       <= '0;
         len       <= '0;
         cnt       <= '0;
         checksum  <= '0;
         pkt_count <= '0;
         drop_err  <= 1'b0;
      end else begin
         drop_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (self_addr) begin
                     drop_err <= 1'b1;
                  end else begin
                     dest     <= bus.req_dest;
                     src      <= bus.req_src;
                     len      <= bus.req_len;
                     cnt      <= bus.req_len;
                     checksum <= '0;
                     state    <= HEAD;
                  end
               end
            end
            HEAD: begin
               if (bus.enq) begin
                  state <= (len != '0) ? BODY : TAIL;
               end
            end
            BODY: begin
               if (bus.enq) begin
                  checksum <= checksum ^ bus.pay_data;
                  cnt      <= cnt - 1'b1;
                  if (cnt == len_width'(1)) begin
                     state <= TAIL;
                  end
               end
            end
            TAIL: begin
               if (bus.enq) begin
                  pkt_count <= pkt_count + 16'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_noc_flit_injector.sv
// Randomised scoreboard bench for noc_flit_injector: the driver queues
// expected flits from a packet-level model, monitors pop and compare.
module tb_noc_flit_injector;
   localparam int FW = 32;
   localparam int AW = 4;
   localparam int LW = 4;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   noc_flit_injector_if #(.flit_width(FW), .addr_width(AW), .len_width(LW)) b0 ();
   noc_flit_injector_if #(.flit_width(FW), .addr_width(AW), .len_width(LW)) b1 ();

   noc_flit_injector #(
      .flit_width(FW), .addr_width(AW), .len_width(LW), .allow_loopback(1'b0)
   ) u0 (
      .clock(clock), .reset(reset), .bus(b0)
   );

   noc_flit_injector #(
      .flit_width(FW), .addr_width(AW), .len_width(LW), .allow_loopback(1'b1)
   ) u1 (
      .clock(clock), .reset(reset), .bus(b1)
   );

   int errors = 0;
   int checks = 0;
   int enq0 = 0;
   int enq1 = 0;
   int model_cnt = 0;
   logic [FW-1:0] exp0[$];
   logic [FW-1:0] exp1[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Packet-level model of the flit encoding
   function automatic logic [FW-1:0] head_of(input int d, input int s,
                                             input int l);
      longint v;
      v = 64'h4000_0000 + longint'(d) * (2 ** 26)
        + longint'(s) * (2 ** 22) + longint'(l) * (2 ** 18);
      return v[FW-1:0];
   endfunction

   function automatic logic [FW-1:0] tail_of(input logic [FW-3:0] x);
      longint v;
      v = 64'h8000_0000 + longint'(x);
      return v[FW-1:0];
   endfunction

   // Monitor for the no-loopback instance
   always @(negedge clock) begin
      if (!reset && b0.enq) begin
         enq0++;
         chk("enq0_while_full", b0.full, 0);
         if (exp0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL flit0_unexpected: got %0h want none", b0.flit_out);
         end else begin
            chk("flit0", b0.flit_out, exp0.pop_front());
         end
      end
   end

   // Monitor for the loopback-enabled instance
   always @(negedge clock) begin
      if (!reset && b1.enq) begin
         enq1++;
         if (exp1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL flit1_unexpected: got %0h want none", b1.flit_out);
         end else begin
            chk("flit1", b1.flit_out, exp1.pop_front());
         end
      end
   end

   task automatic idle0();
      b0.req_valid = 1'b0;
      b0.pay_valid = 1'b0;
      b0.full      = 1'b0;
   endtask

   // Entered and left at posedge+1. stall_w/stall_n force full after
   // stall_w payload words; rst_w pulses reset after rst_w words.
   task automatic send(input int d, input int s, input int l,
                       input int bub, input int fpct,
                       input int stall_w, input int stall_n,
                       input int rst_w);
      logic [FW-3:0] words[$];
      logic [FW-3:0] x;
      int acc, cyc, pr_seen, e0, sn;
      bit stalling, clean;
      x = '0;
      acc = 0;
      cyc = 0;
      pr_seen = 0;
      sn = stall_n;
      clean = (bub == 0) && (fpct == 0) && (stall_n == 0);
      for (int i = 0; i < l; i++) begin
         words.push_back(FW'($urandom) & 30'h3fff_ffff);
         x ^= words[i];
      end
      b0.req_valid = 1'b1;
      b0.req_dest  = AW'(d);
      b0.req_src   = AW'(s);
      b0.req_len   = LW'(l);
      b0.full      = 1'b0;
      b0.pay_valid = 1'b0;
      @(negedge clock);
      chk("req_ready", b0.req_ready, 1);
      e0 = enq0;
      if (d != s) begin
         exp0.push_back(head_of(d, s, l));
         foreach (words[i]) exp0.push_back({2'b00, words[i]});
         exp0.push_back(tail_of(x));
      end
      @(posedge clock);
      #1;
      b0.req_valid = 1'b0;
      if (d == s) begin
         chk("drop_err_set", b0.drop_err, 1);
         chk("drop_busy", b0.busy, 0);
         @(posedge clock);
         #1;
         chk("drop_err_clr", b0.drop_err, 0);
         chk("drop_no_enq", enq0 - e0, 0);
         return;
      end
      chk("busy", b0.busy, 1);
      while (b0.busy && cyc < 300) begin
         stalling = (acc == stall_w) && (sn > 0);
         if (stalling) begin
            b0.full      = 1'b1;
            b0.pay_valid = sn[0];
            b0.pay_data  = words[acc];
            sn--;
         end else begin
            b0.full      = ($urandom_range(99) < fpct);
            b0.pay_valid = (acc < l) && ($urandom_range(99) >= bub);
            b0.pay_data  = (acc < l) ? words[acc] : (FW - 2)'($urandom);
         end
         @(negedge clock);
         if (stalling) begin
            chk("stall_flit", b0.flit_out, {2'b00, words[acc]});
            chk("stall_enq", b0.enq, 0);
         end
         if (b0.pay_ready) pr_seen = 1;
         if (b0.pay_valid && b0.pay_ready) acc++;
         if (rst_w >= 0 && acc == rst_w) begin
            #2;
            reset = 1'b1;
            #1;
            chk("rst_enq", b0.enq, 0);
            chk("rst_busy", b0.busy, 0);
            chk("rst_req_ready", b0.req_ready, 1);
            chk("rst_pkt_count", b0.pkt_count, 0);
            exp0.delete();
            model_cnt = 0;
            idle0();
            @(posedge clock);
            #1;
            reset = 1'b0;
            return;
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      idle0();
      chk("pkt_done", (cyc < 300), 1);
      chk("pay_handshakes", acc, l);
      if (l == 0) chk("no_pay_ready", pr_seen, 0);
      model_cnt++;
      chk("pkt_count", b0.pkt_count, model_cnt & 16'hffff);
      chk("enq_total", enq0 - e0, l + 2);
      if (clean) chk("cycles", cyc, l + 2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      int d, s, l;
      reset = 1'b1;
      idle0();
      b0.req_dest = '0;
      b0.req_src  = '0;
      b0.req_len  = '0;
      b0.pay_data = '0;
      b1.req_valid = 1'b0;
      b1.req_dest  = '0;
      b1.req_src   = '0;
      b1.req_len   = '0;
      b1.pay_valid = 1'b0;
      b1.pay_data  = '0;
      b1.full      = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset_enq", b0.enq, 0);
      chk("reset_req_ready", b0.req_ready, 1);
      chk("reset_busy", b0.busy, 0);
      chk("reset_pkt_count", b0.pkt_count, 0);
      chk("reset_drop_err", b0.drop_err, 0);
      chk("reset_flit_out", b0.flit_out, 0);
      chk("reset_pay_ready", b0.pay_ready, 0);

      send(3, 5, 2, 0, 0, -1, 0, -1);
      send(1, 2, 0, 0, 0, -1, 0, -1);
      send(4, 4, 1, 0, 0, -1, 0, -1);
      send(7, 9, 3, 0, 0, 1, 5, -1);
      send(15, 0, 15, 0, 0, -1, 0, -1);

      // Self-addressed packet is legal on the loopback instance
      b1.req_valid = 1'b1;
      b1.req_dest  = 4'd4;
      b1.req_src   = 4'd4;
      b1.req_len   = 4'd1;
      exp1.push_back(head_of(4, 4, 1));
      exp1.push_back(32'h0000_0005);
      exp1.push_back(tail_of(30'h5));
      @(posedge clock);
      #1;
      b1.req_valid = 1'b0;
      b1.pay_valid = 1'b1;
      b1.pay_data  = 30'h5;
      repeat (6) @(posedge clock);
      #1;
      b1.pay_valid = 1'b0;
      chk("lb_enq_total", enq1, 3);
      chk("lb_pkt_count", b1.pkt_count, 1);
      chk("lb_drop_err", b1.drop_err, 0);

      send(2, 9, 4, 0, 0, -1, 0, 2);
      send(2, 9, 3, 0, 0, -1, 0, -1);

      for (int n = 0; n < 24; n++) begin
         d = $urandom_range(15);
         s = (n % 6 == 5) ? d : $urandom_range(15);
         l = $urandom_range(15);
         send(d, s, l, 30, 30, -1, 0, -1);
      end

      repeat (2) @(posedge clock);
      #1;
      chk("exp0_empty", exp0.size(), 0);
      chk("exp1_empty", exp1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
